// File: rtl/mem_pkg.sv
// Shared types and MMIO address map for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_LED  = 2'd1,
    TGT_SW   = 2'd2,
    TGT_NONE = 2'd3
  } tgt_t;

  localparam logic [8:0] MMIO_LED_ADDR = 9'h100;
  localparam logic [8:0] MMIO_SW_ADDR  = 9'h140;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM; write and read sample happen on the same enabled edge.
module ram_sp #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AW        = 8,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready request, WAIT wait states, one-cycle response pulse.
// Optional LED/switch MMIO window enabled by defining MEM_RESPONDER_MMIO_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned WAIT      = 1,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WAIT > 15) begin : g_wait_chk
    $error("mem_responder: WAIT must be in 0..15");
  end

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_req_ready, r_rsp_valid;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_sel_ram;
  logic [DATA_W-1:0]  r_rdata_oth;
  logic               r_err;

  logic               w_accept, w_live, w_commit;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  tgt_t               w_tgt;
  logic [DATA_W-1:0]  w_ram_rdata;
  logic [DATA_W-1:0]  w_mmio_rdata;

  assign w_accept = req_valid && r_req_ready;

  // With WAIT=0 the commit shares the accept edge, so use the live request
  assign w_live  = (r_state != BUSY);
  assign w_we    = w_live ? req_we    : r_we;
  assign w_addr  = w_live ? req_addr  : r_addr;
  assign w_wdata = w_live ? req_wdata : r_wdata;

  assign w_commit = ((r_state == BUSY) && (r_cnt == '0)) || (w_accept && (WAIT == 0));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (WAIT == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_W'(WAIT - 1);
          end
        end else if (r_state == RESP) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt != BUSY);
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  // Request capture for the wait-state path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_comb begin
    w_tgt = TGT_NONE;
    if (32'(w_addr) < DEPTH) begin
      w_tgt = TGT_RAM;
    end
`ifdef MEM_RESPONDER_MMIO_EN
    else if (w_addr == ADDR_W'(MMIO_LED_ADDR)) begin
      w_tgt = TGT_LED;
    end else if (w_addr == ADDR_W'(MMIO_SW_ADDR)) begin
      w_tgt = TGT_SW;
    end
`endif
  end

  ram_sp #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_commit && w_we  && (w_tgt == TGT_RAM)),
    .i_re    (w_commit && !w_we && (w_tgt == TGT_RAM)),
    .i_addr  (w_addr[RAM_AW-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

`ifdef MEM_RESPONDER_MMIO_EN
  logic [7:0] r_led, r_sw_meta, r_sw_sync;

  if ((32'(MMIO_LED_ADDR) < DEPTH) || (32'(MMIO_SW_ADDR) < DEPTH)) begin : g_mmio_chk
    $error("mem_responder: MMIO address overlaps RAM range");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (w_commit && w_we && (w_tgt == TGT_LED)) r_led <= w_wdata[7:0];
    end
  end

  assign w_mmio_rdata = (w_tgt == TGT_LED) ? DATA_W'(r_led) :
                        (w_tgt == TGT_SW)  ? DATA_W'(r_sw_sync) : '0;
  assign led_out      = r_led;
`else
  logic w_unused_sw;
  assign w_unused_sw  = ^sw_in;
  assign w_mmio_rdata = '0;
  assign led_out      = '0;
`endif

  // RAM reads come straight from the RAM output register; everything else from r_rdata_oth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_ram   <= 1'b0;
      r_rdata_oth <= '0;
      r_err       <= 1'b0;
    end else if (w_commit) begin
      r_sel_ram   <= (w_tgt == TGT_RAM);
      r_rdata_oth <= w_we ? '0 : w_mmio_rdata;
      r_err       <= (w_tgt == TGT_NONE) || ((w_tgt == TGT_SW) && w_we);
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_sel_ram ? w_ram_rdata : r_rdata_oth;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances with WAIT = 0, 1, 3, 4.
module tb_mem_responder;

  localparam int NI = 4;
  localparam int NV = 12;

  logic        clk;
  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [8:0]  req_addr  [NI];
  logic [15:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic [15:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic [7:0]  sw_in     [NI];
  logic [7:0]  led_out   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
    mem_responder #(.WAIT(W)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .sw_in     (sw_in[g]),
      .led_out   (led_out[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One request on instance i; lat = negedges after the accept edge until rsp_valid (-1 on timeout)
  task automatic do_req(input int i, input bit we, input logic [8:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic err, output int lat);
    int k;
    rd  = '0;
    err = 1'b0;
    lat = -1;
    @(negedge clk);
    k = 0;
    while (req_ready[i] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    req_we[i]    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid[i] === 1'b1) begin
        lat = c;
        rd  = rsp_rdata[i];
        err = rsp_err[i];
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    bit          chk_rd;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [NV];

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    bit          seen;

    for (int i = 0; i < NI; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      sw_in[i]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("rst%0d_rspv", i),  32'(rsp_valid[i]), 32'd0);
      check($sformatf("rst%0d_rdata", i), 32'(rsp_rdata[i]), 32'd0);
      check($sformatf("rst%0d_err", i),   32'(rsp_err[i]),   32'd0);
      check($sformatf("rst%0d_led", i),   32'(led_out[i]),   32'd0);
    end

    // Table: WAIT=1 instance
    vt[0]  = '{1'b1, 9'h003, 16'h0005, 1'b0, 16'h0000, 1'b0};
    vt[1]  = '{1'b0, 9'h003, 16'h0000, 1'b1, 16'h0005, 1'b0};
    vt[2]  = '{1'b1, 9'h0FF, 16'h7777, 1'b0, 16'h0000, 1'b0};
    vt[3]  = '{1'b0, 9'h1FF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[4]  = '{1'b1, 9'h1FF, 16'h1234, 1'b1, 16'h0000, 1'b1};
    vt[5]  = '{1'b0, 9'h0FF, 16'h0000, 1'b1, 16'h7777, 1'b0};
    vt[6]  = '{1'b1, 9'h000, 16'hABCD, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{1'b0, 9'h000, 16'h0000, 1'b1, 16'hABCD, 1'b0};
`ifdef MEM_RESPONDER_MMIO_EN
    vt[8]  = '{1'b0, 9'h100, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[11] = '{1'b0, 9'h140, 16'h0000, 1'b1, 16'h0000, 1'b0};
`else
    vt[8]  = '{1'b0, 9'h100, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[11] = '{1'b0, 9'h140, 16'h0000, 1'b1, 16'h0000, 1'b1};
`endif
    vt[9]  = '{1'b1, 9'h140, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vt[10] = '{1'b0, 9'h003, 16'h0000, 1'b1, 16'h0005, 1'b0};

    for (int n = 0; n < NV; n++) begin
      do_req(1, vt[n].we, vt[n].addr, vt[n].wdata, rd, er, lat);
      check($sformatf("v%0d_lat", n), 32'(lat), 32'd1);
      check($sformatf("v%0d_err", n), 32'(er), 32'(vt[n].exp_err));
      if (vt[n].chk_rd) check($sformatf("v%0d_rdata", n), 32'(rd), 32'(vt[n].exp_rd));
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", n), 32'(rsp_valid[1]), 32'd0);
    end

`ifdef MEM_RESPONDER_MMIO_EN
    do_req(1, 1'b1, 9'h100, 16'h00C3, rd, er, lat);
    check("led_wr_err", 32'(er), 32'd0);
    check("led_out", 32'(led_out[1]), 32'h00C3);
    sw_in[1] = 8'h5A;
    repeat (2) @(negedge clk);
    do_req(1, 1'b0, 9'h140, 16'h0000, rd, er, lat);
    check("sw_rd_data", 32'(rd), 32'h005A);
    check("sw_rd_err", 32'(er), 32'd0);
    do_req(1, 1'b1, 9'h140, 16'h00FF, rd, er, lat);
    check("sw_wr_err", 32'(er), 32'd1);
    do_req(1, 1'b0, 9'h100, 16'h0000, rd, er, lat);
    check("led_rd_data", 32'(rd), 32'h00C3);
`endif

    // Back-to-back reads, WAIT=0
    for (int a = 0; a < 4; a++) begin
      do_req(0, 1'b1, 9'(a), 16'h00A0 + 16'(a), rd, er, lat);
      check($sformatf("b2b_pre%0d_lat", a), 32'(lat), 32'd0);
    end
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 9'h000;
    for (int a = 0; a < 4; a++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d_rspv", a),  32'(rsp_valid[0]), 32'd1);
      check($sformatf("b2b%0d_rdata", a), 32'(rsp_rdata[0]), 32'h00A0 + 32'(a));
      check($sformatf("b2b%0d_ready", a), 32'(req_ready[0]), 32'd1);
      if (a < 3) req_addr[0] = 9'(a + 1);
      else       req_valid[0] = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_rspv", 32'(rsp_valid[0]), 32'd0);

    // Hold-off, WAIT=3, req_valid held high
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 9'h005;
    req_wdata[2] = 16'h0055;
    for (int c = 0; c <= 12; c++) begin
      bit exp_hi;
      exp_hi = (c == 0) ? 1'b1 : (((c - 1) % 4) == 3);
      check($sformatf("hold%0d_ready", c), 32'(req_ready[2]), 32'(exp_hi));
      check($sformatf("hold%0d_rspv", c),  32'(rsp_valid[2]), (c == 0) ? 32'd0 : 32'(exp_hi));
      if (c == 12) req_valid[2] = 1'b0;
      @(negedge clk);
    end
    check("hold_end_rspv", 32'(rsp_valid[2]), 32'd0);

    // Reset mid-BUSY, WAIT=4
    do_req(3, 1'b1, 9'h007, 16'h1111, rd, er, lat);
    check("rb_pre_lat", 32'(lat), 32'd4);
    @(negedge clk);
    req_valid[3] = 1'b1;
    req_we[3]    = 1'b1;
    req_addr[3]  = 9'h007;
    req_wdata[3] = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[3] = 1'b0;
    req_we[3]    = 1'b0;
    check("rb_busy_ready", 32'(req_ready[3]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst[3] = 1'b1;
    #1;
    check("rb_rst_ready", 32'(req_ready[3]), 32'd1);
    check("rb_rst_rspv",  32'(rsp_valid[3]), 32'd0);
    check("rb_rst_rdata", 32'(rsp_rdata[3]), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid[3] !== 1'b0) seen = 1'b1;
    end
    rst[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[3] !== 1'b0) seen = 1'b1;
    end
    check("rb_no_rsp", 32'(seen), 32'd0);
    check("rb_idle_ready", 32'(req_ready[3]), 32'd1);
    do_req(3, 1'b0, 9'h007, 16'h0000, rd, er, lat);
    check("rb_read_lat",   32'(lat), 32'd4);
    check("rb_read_rdata", 32'(rd),  32'h1111);
    check("rb_read_err",   32'(er),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
